// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: widths, FSM state encoding and the
// two-bit command codes carried in the top of each received word.
package spi_pkg;

   localparam int ADDR_SIZE = 8;
   localparam int CNT_W     = 4;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CHK_CMD   = 3'd1;
   localparam logic [2:0] ST_WRITE     = 3'd2;
   localparam logic [2:0] ST_READ_ADD  = 3'd3;
   localparam logic [2:0] ST_READ_DATA = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      CHK_CMD   = ST_CHK_CMD,
      WRITE     = ST_WRITE,
      READ_ADD  = ST_READ_ADD,
      READ_DATA = ST_READ_DATA
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_bus_if.sv
// SPI wire bundle plus the word-level RAM handshake.
// Ports: SS_n/MOSI/MISO serial side, rx_data/rx_valid to the RAM,
// tx_data/tx_valid back from the RAM. slave = this block's view.
interface spi_bus_if #(
   parameter int ADDR_SIZE = spi_pkg::ADDR_SIZE
);
   logic                 SS_n;
   logic                 MOSI;
   logic                 MISO;
   logic [ADDR_SIZE+1:0] rx_data;
   logic                 rx_valid;
   logic [ADDR_SIZE-1:0] tx_data;
   logic                 tx_valid;

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );
endinterface

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser that owns MISO and the tx count.
// Ports: clk, rst, clr_i (abort), load_i/data_i, miso_o, last_o.
module spi_tx_shifter
   import spi_pkg::*;
#(
   parameter int W = ADDR_SIZE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         miso_o,
   output logic         last_o
);

   logic [W-1:0]     sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             miso_q, miso_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         miso_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         miso_q <= miso_d;
      end
   end

   // One load per frame: done_q blocks reloads until the frame ends.
   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = done_q;
      miso_d = miso_q;
      if (clr_i) begin
         sh_d   = '0;
         cnt_d  = '0;
         busy_d = 1'b0;
         done_d = 1'b0;
         miso_d = 1'b0;
      end else if (load_i && !busy_q && !done_q) begin
         miso_d = data_i[W-1];
         sh_d   = {data_i[W-2:0], 1'b0};
         cnt_d  = CNT_W'(W-1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (cnt_q == '0) begin
            miso_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            miso_d = sh_q[W-1];
            sh_d   = {sh_q[W-2:0], 1'b0};
            cnt_d  = cnt_q - CNT_W'(1);
         end
      end
   end

   assign miso_o = miso_q;
   assign last_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit cmd/data words for the RAM
// and serialises read data back. Ports: clk, rst, bus (spi_bus_if.slave).
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int ADDR_SIZE = spi_pkg::ADDR_SIZE
) (
   input  logic     clk,
   input  logic     rst,
   spi_bus_if.slave bus
);

   localparam int RW = ADDR_SIZE + 2;

   state_e           state_q, state_d;
   logic [RW-1:0]    rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rx_done_q, rx_done_d;
   logic             rd_seen_q, rd_seen_d;
   logic             tx_load;
   logic             tx_last;
   logic             miso;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         cnt_q      <= '0;
         rx_done_q  <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         cnt_q      <= cnt_d;
         rx_done_q  <= rx_done_d;
         rd_seen_q  <= rd_seen_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      cnt_d      = cnt_q;
      rx_done_d  = rx_done_q;
      rd_seen_d  = rd_seen_q;
      tx_load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            rx_done_d = 1'b0;
            if (!bus.SS_n) state_d = CHK_CMD;
         end
         CHK_CMD: begin
            if (bus.SS_n) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               rx_data_d = {{(RW-1){1'b0}}, bus.MOSI};
               cnt_d     = CNT_W'(RW-2);
               if (!bus.MOSI)     state_d = WRITE;
               else if (rd_seen_q) state_d = READ_DATA;
               else               state_d = READ_ADD;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (bus.SS_n) begin
               state_d   = IDLE;
               cnt_d     = '0;
               rx_done_d = 1'b0;
            end else if (!rx_done_q) begin
               rx_data_d = {rx_data_q[RW-2:0], bus.MOSI};
               if (cnt_q == '0) begin
                  rx_valid_d = 1'b1;
                  rx_done_d  = 1'b1;
                  // Flag the address phase as soon as its word is complete.
                  if (state_q == READ_ADD) rd_seen_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else if (state_q == READ_DATA) begin
               tx_load = bus.tx_valid;
               if (tx_last) rd_seen_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   spi_tx_shifter #(
      .W(ADDR_SIZE)
   ) u_tx (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (bus.SS_n),
      .load_i (tx_load),
      .data_i (bus.tx_data),
      .miso_o (miso),
      .last_o (tx_last)
   );

   assign bus.MISO     = miso;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: expected words and MISO bits are
// queued with their due cycle and compared by a negedge monitor.
module tb_spi_slave_if;
   import spi_pkg::*;

   typedef struct {
      int         cyc;
      logic [9:0] d;
   } rx_exp_t;

   typedef struct {
      int   cyc;
      logic b;
   } miso_exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   errs;
   int   checks;

   rx_exp_t   rxq[$];
   miso_exp_t misoq[$];

   spi_bus_if bus ();

   spi_slave_if dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic exp_rx(input int c, input logic [9:0] d);
      rx_exp_t e;
      e.cyc = c;
      e.d   = d;
      rxq.push_back(e);
   endtask

   task automatic exp_miso(input int c, input logic b);
      miso_exp_t e;
      e.cyc = c;
      e.b   = b;
      misoq.push_back(e);
   endtask

   always @(negedge clk) begin
      miso_exp_t m;
      rx_exp_t   r;
      if (misoq.size() > 0 && misoq[0].cyc == cyc) begin
         m = misoq.pop_front();
         chk("miso", bus.MISO, m.b);
      end
      if (bus.rx_valid) begin
         if (rxq.size() > 0 && rxq[0].cyc == cyc) begin
            r = rxq.pop_front();
            chk("rx_data", bus.rx_data, r.d);
         end else begin
            chk("rx_valid_unexpected", bus.rx_valid, 1'b0);
         end
      end else if (rxq.size() > 0 && rxq[0].cyc <= cyc) begin
         r = rxq.pop_front();
         chk("rx_valid_missing", bus.rx_valid, 1'b1);
      end
   end

   // Drive nbits of w MSB-first; k is the cycle SS_n was lowered.
   task automatic frame(input logic [9:0] w, input int nbits,
                        input bit abort_last, input bit hold,
                        output int k);
      @(negedge clk);
      bus.SS_n = 1'b0;
      bus.MOSI = 1'b0;
      k = cyc;
      if (nbits == 10 && !abort_last) exp_rx(k + 11, w);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.MOSI = w[9-i];
         if (abort_last && i == nbits - 1) bus.SS_n = 1'b1;
      end
      if (!abort_last && !hold) begin
         @(negedge clk);
         bus.SS_n = 1'b1;
      end
   endtask

   // Read reply after a held 10-bit frame; active selects real output.
   task automatic rd_tail(input int k, input logic [7:0] d,
                          input bit active);
      @(negedge clk);
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      for (int j = 0; j < 8; j++)
         exp_miso(k + 13 + j, active ? d[7-j] : 1'b0);
      exp_miso(k + 21, 1'b0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (9) @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hFF;
      exp_miso(k + 23, 1'b0);
      exp_miso(k + 24, 1'b0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      @(negedge clk);
      bus.SS_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      errs         = 0;
      checks       = 0;
      cyc          = 0;
      rst          = 1'b1;
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_rx_data", bus.rx_data, 10'h000);
      chk("rst_miso", bus.MISO, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Write-address frame
      frame({CMD_WR_ADDR, 8'h05}, 10, 1'b0, 1'b0, k);
      exp_miso(k + 11, 1'b0);
      @(negedge clk);

      // Read-address frame: tx_valid must not reach MISO
      frame({CMD_RD_ADDR, 8'hAA}, 10, 1'b0, 1'b1, k);
      rd_tail(k, 8'hC3, 1'b0);

      // Read-data frame: C3 serialised MSB first
      frame({CMD_RD_DATA, 8'h0F}, 10, 1'b0, 1'b1, k);
      rd_tail(k, 8'hC3, 1'b1);

      // Abort after 6 bits, then a full write-data frame
      frame({CMD_WR_DATA, 8'hFF}, 6, 1'b0, 1'b0, k);
      frame({CMD_WR_DATA, 8'hFF}, 10, 1'b0, 1'b0, k);

      // SS_n rises with the 10th bit, then back-to-back frames
      frame({CMD_WR_DATA, 8'h3C}, 10, 1'b1, 1'b0, k);
      frame({CMD_WR_ADDR, 8'h81}, 10, 1'b0, 1'b0, k);
      frame({CMD_WR_DATA, 8'h7E}, 10, 1'b0, 1'b0, k);

      // Reset in the middle of a read transfer
      frame({CMD_RD_ADDR, 8'h11}, 10, 1'b0, 1'b0, k);
      frame({CMD_RD_DATA, 8'h22}, 10, 1'b0, 1'b1, k);
      @(negedge clk);
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hFF;
      for (int j = 0; j < 5; j++) exp_miso(k + 13 + j, 1'b1);
      exp_miso(k + 18, 1'b0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_rx_valid", bus.rx_valid, 1'b0);
      rst      = 1'b0;
      bus.SS_n = 1'b1;
      @(negedge clk);

      // Flag cleared by reset: this frame is a read-address
      frame({CMD_RD_DATA, 8'h44}, 10, 1'b0, 1'b1, k);
      rd_tail(k, 8'hFF, 1'b0);
      frame({CMD_RD_DATA, 8'h55}, 10, 1'b0, 1'b1, k);
      rd_tail(k, 8'hA5, 1'b1);

      repeat (4) @(negedge clk);
      chk("rxq_drained", rxq.size(), 0);
      chk("misoq_drained", misoq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
